// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the execute stage: ALU sub-ops, result selects, divider states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ex_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 5;
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    // ALU sub-op encodings as produced by the id decoder
    localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

    // Result-select encodings
    localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
    localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [ALUSEL_W-1:0] EXE_RES_ARITH = 3'b100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // ID/EX latch contents
    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [DATA_W-1:0]   rdata1;
        logic [DATA_W-1:0]   rdata2;
        logic [REG_AW-1:0]   waddr;
        logic                we;
    } idex_t;

    // EX/MEM register contents
    typedef struct packed {
        logic                we;
        logic [REG_AW-1:0]   waddr;
        logic [DATA_W-1:0]   wdata;
        logic                whilo;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
    } exmem_t;

    // Magnitude of a value, treating it as two's complement only when sgn is set
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle with sign fix-up on completion.
// Latency: 34 cycles start-to-idle (IDLE, 32 x BUSY, DONE); divide-by-zero goes IDLE->DONE in 2.
// Backpressure: hold keeps DONE (and its result) until released; abort returns to IDLE at once.
module ex_stage_div_iter
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              abort,
    input  logic              hold,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quot_o,
    output logic [DATA_W-1:0] rem_o
);

    div_state_e        state_q;
    logic [4:0]        cnt_q;
    logic [DATA_W-1:0] dvd_q;      // dividend magnitude shifting out, quotient bits shifting in
    logic [DATA_W-1:0] dvs_q;      // divisor magnitude
    logic [DATA_W-1:0] part_q;     // partial remainder
    logic              neg_quot_q;
    logic              neg_rem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] rem_q;

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              ge;
    logic [DATA_W-1:0] step_part;
    logic [DATA_W-1:0] step_dvd;

    // One restoring shift-subtract step on the current partial remainder
    always_comb begin
        shifted   = {part_q, dvd_q[DATA_W-1]};
        trial     = shifted - {1'b0, dvs_q};
        ge        = ~trial[DATA_W];
        step_part = ge ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
        step_dvd  = {dvd_q[DATA_W-2:0], ge};
    end

    // Divider FSM with registered result; abort discards any partial work
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            part_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else if (abort) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            part_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        cnt_q      <= '0;
                        part_q     <= '0;
                        dvd_q      <= abs_val(dividend_i, signed_op);
                        dvs_q      <= abs_val(divisor_i, signed_op);
                        neg_quot_q <= signed_op & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                        neg_rem_q  <= signed_op & dividend_i[DATA_W-1];
                        if (divisor_i == '0) begin
                            quot_q  <= '1;
                            rem_q   <= dividend_i;
                            state_q <= DIV_DONE;
                        end else begin
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    dvd_q  <= step_dvd;
                    part_q <= step_part;
                    if (cnt_q == 5'd31) begin
                        cnt_q   <= '0;
                        quot_q  <= neg_quot_q ? -step_dvd : step_dvd;
                        rem_q   <= neg_rem_q ? -step_part : step_part;
                        state_q <= DIV_DONE;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DIV_DONE: begin
                    if (!hold) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == DIV_BUSY);
    assign done_o = (state_q == DIV_DONE);
    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, single-cycle logic/shift ALU, optional iterative divider (EX_DIV_EN).
// Latency: ALU result combinational on ex_*, registered on mem_* one edge later; divide occupies EX 34 cycles.
// Backpressure: stall_i holds every register; stallreq_o holds upstream while a divide is in flight.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic [ALUOP_W-1:0]  aluop_i,
    input  logic [ALUSEL_W-1:0] alusel_i,
    input  logic [DATA_W-1:0]   rdata1_i,
    input  logic [DATA_W-1:0]   rdata2_i,
    input  logic [REG_AW-1:0]   waddr_reg_i,
    input  logic                we_reg_i,
    output logic                ex_we_reg_o,
    output logic [REG_AW-1:0]   ex_waddr_reg_o,
    output logic [DATA_W-1:0]   ex_wdata_o,
    output logic                mem_we_reg_o,
    output logic [REG_AW-1:0]   mem_waddr_reg_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic                mem_whilo_o,
    output logic [DATA_W-1:0]   mem_hi_o,
    output logic [DATA_W-1:0]   mem_lo_o,
    output logic                stallreq_o
);

    idex_t             idex_q, idex_d;
    exmem_t            exmem_q, exmem_d;
    exmem_t            ex_res;

    logic [DATA_W-1:0] logic_res;
    logic              logic_ok;
    logic [DATA_W-1:0] shift_res;
    logic              shift_ok;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ok;

    logic              div_wr;     // a divide is in the latch and its result is ready
    logic [DATA_W-1:0] div_hi;
    logic [DATA_W-1:0] div_lo;

    // ID/EX latch next value: flush squashes to NOP, any stall holds
    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d       = '0;
            idex_d.aluop = EXE_NOP_OP;
        end else if (!(stall_i || stallreq_o)) begin
            idex_d.aluop  = aluop_i;
            idex_d.alusel = alusel_i;
            idex_d.rdata1 = rdata1_i;
            idex_d.rdata2 = rdata2_i;
            idex_d.waddr  = waddr_reg_i;
            idex_d.we     = we_reg_i;
        end
    end

    // ID/EX latch register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    // Logic/shift ALU; the result select must agree with the op class
    always_comb begin
        logic_res = '0;
        logic_ok  = 1'b0;
        shift_res = '0;
        shift_ok  = 1'b0;
        case (idex_q.aluop)
            EXE_OR_OP:  begin logic_res = idex_q.rdata1 | idex_q.rdata2;    logic_ok = 1'b1; end
            EXE_AND_OP: begin logic_res = idex_q.rdata1 & idex_q.rdata2;    logic_ok = 1'b1; end
            EXE_XOR_OP: begin logic_res = idex_q.rdata1 ^ idex_q.rdata2;    logic_ok = 1'b1; end
            EXE_NOR_OP: begin logic_res = ~(idex_q.rdata1 | idex_q.rdata2); logic_ok = 1'b1; end
            EXE_SLL_OP: begin shift_res = idex_q.rdata2 << idex_q.rdata1[4:0]; shift_ok = 1'b1; end
            EXE_SRL_OP: begin shift_res = idex_q.rdata2 >> idex_q.rdata1[4:0]; shift_ok = 1'b1; end
            EXE_SRA_OP: begin shift_res = $signed(idex_q.rdata2) >>> idex_q.rdata1[4:0]; shift_ok = 1'b1; end
            default:    ;
        endcase
        alu_res = '0;
        alu_ok  = 1'b0;
        case (idex_q.alusel)
            EXE_RES_LOGIC: begin alu_res = logic_ok ? logic_res : '0; alu_ok = logic_ok; end
            EXE_RES_SHIFT: begin alu_res = shift_ok ? shift_res : '0; alu_ok = shift_ok; end
            default:       ;
        endcase
    end

`ifdef EX_DIV_EN
    logic is_div;
    logic div_busy;
    logic div_done;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W-1:0] div_rem;

    assign is_div = (idex_q.aluop == EXE_DIV_OP) || (idex_q.aluop == EXE_DIVU_OP);

    ex_stage_div_iter u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (is_div),
        .signed_op  (idex_q.aluop == EXE_DIV_OP),
        .abort      (flush_i),
        .hold       (stall_i),
        .dividend_i (idex_q.rdata1),
        .divisor_i  (idex_q.rdata2),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    // Stall upstream until the divide reaches DONE; a flush releases at once
    assign stallreq_o = ((is_div && !div_done) || div_busy) && !flush_i;
    assign div_wr     = is_div && div_done;
    assign div_hi     = div_rem;
    assign div_lo     = div_quot;
`else
    assign stallreq_o = 1'b0;
    assign div_wr     = 1'b0;
    assign div_hi     = '0;
    assign div_lo     = '0;
`endif

    // Combinational EX result, also forwarded to id
    always_comb begin
        ex_res       = '0;
        ex_res.we    = idex_q.we && (alu_ok || div_wr);
        ex_res.waddr = idex_q.waddr;
        ex_res.wdata = alu_res;
        ex_res.whilo = div_wr;
        ex_res.hi    = div_wr ? div_hi : '0;
        ex_res.lo    = div_wr ? div_lo : '0;
    end

    assign ex_we_reg_o    = ex_res.we;
    assign ex_waddr_reg_o = ex_res.waddr;
    assign ex_wdata_o     = ex_res.wdata;

    // EX/MEM next value: flush bubbles, downstream stall holds, own stall bubbles
    always_comb begin
        exmem_d = exmem_q;
        if (flush_i)         exmem_d = '0;
        else if (stall_i)    exmem_d = exmem_q;
        else if (stallreq_o) exmem_d = '0;
        else                 exmem_d = ex_res;
    end

    // EX/MEM register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) exmem_q <= '0;
        else     exmem_q <= exmem_d;
    end

    assign mem_we_reg_o    = exmem_q.we;
    assign mem_waddr_reg_o = exmem_q.waddr;
    assign mem_wdata_o     = exmem_q.wdata;
    assign mem_whilo_o     = exmem_q.whilo;
    assign mem_hi_o        = exmem_q.hi;
    assign mem_lo_o        = exmem_q.lo;

endmodule
